// File: rtl/uart_boot_ctrl_if.sv
// Bundle of the receiver handshake and program-memory/CPU control signals
// between uart_boot_ctrl and its environment.
interface uart_boot_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [31:0]       rx_word;
    logic              rx_done;
    logic              rx_one_byte;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              load_done;
    logic              cmd_err;

    // Controller side.
    modport master (
        input  rx_word,
        input  rx_done,
        output rx_one_byte,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_hold,
        output busy,
        output load_done,
        output cmd_err
    );

    // Receiver / memory / CPU side.
    modport slave (
        output rx_word,
        output rx_done,
        input  rx_one_byte,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_hold,
        input  busy,
        input  load_done,
        input  cmd_err
    );
endinterface

// File: rtl/uart_boot_ctrl.sv
// Boot command sequencer: decodes WRITE/RUN/HALT from the UART word assembler,
// writes program memory word by word and controls the CPU hold line.
module uart_boot_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 16
) (
    input logic              clk,
    input logic              reset,
    uart_boot_ctrl_if.master bus
);

    localparam logic [7:0] OpWrite = 8'h01;
    localparam logic [7:0] OpRun   = 8'h02;
    localparam logic [7:0] OpHalt  = 8'h03;

    typedef enum logic [2:0] {
        StOpcode,
        StGetAddr,
        StGetLen,
        StGetData,
        StWrite
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StOpcode;
            addr_q          <= '0;
            cnt_q           <= '0;
            bus.rx_one_byte <= 1'b1;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.cpu_hold    <= 1'b1;
            bus.busy        <= 1'b0;
            bus.load_done   <= 1'b0;
            bus.cmd_err     <= 1'b0;
        end else begin
            bus.mem_we    <= 1'b0;
            bus.load_done <= 1'b0;
            bus.cmd_err   <= 1'b0;

            unique case (state_q)
                StOpcode: begin
                    if (bus.rx_done) begin
                        case (bus.rx_word[7:0])
                            OpWrite: begin
                                state_q         <= StGetAddr;
                                bus.rx_one_byte <= 1'b0;
                                bus.busy        <= 1'b1;
                            end
                            OpRun:   bus.cpu_hold <= 1'b0;
                            OpHalt:  bus.cpu_hold <= 1'b1;
                            default: bus.cmd_err  <= 1'b1;
                        endcase
                    end
                end

                StGetAddr: begin
                    if (bus.rx_done) begin
                        addr_q  <= bus.rx_word[ADDR_W-1:0];
                        state_q <= StGetLen;
                    end
                end

                StGetLen: begin
                    if (bus.rx_done) begin
                        cnt_q <= bus.rx_word[LEN_W-1:0];
                        if (bus.rx_word[LEN_W-1:0] == '0) begin
                            // Empty block: finish without touching memory.
                            state_q         <= StOpcode;
                            bus.rx_one_byte <= 1'b1;
                            bus.busy        <= 1'b0;
                            bus.load_done   <= 1'b1;
                        end else begin
                            state_q <= StGetData;
                        end
                    end
                end

                StGetData: begin
                    if (bus.rx_done) begin
                        bus.mem_wdata <= bus.rx_word;
                        bus.mem_addr  <= addr_q;
                        bus.mem_we    <= 1'b1;
                        state_q       <= StWrite;
                    end
                end

                StWrite: begin
                    // rx_done cannot legally arrive here and is dropped if it does.
                    addr_q <= addr_q + 1'b1;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_q         <= StOpcode;
                        bus.rx_one_byte <= 1'b1;
                        bus.busy        <= 1'b0;
                        bus.load_done   <= 1'b1;
                    end else begin
                        state_q <= StGetData;
                    end
                end

                default: begin
                    state_q         <= StOpcode;
                    bus.rx_one_byte <= 1'b1;
                    bus.busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Self-checking bench for uart_boot_ctrl: expected memory writes are queued as
// data words are sent and matched against mem_we strobes.
module tb_uart_boot_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 16;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   n_load = 0;
    int   n_cmd_err = 0;

    exp_t        exp_q[$];
    logic [31:0] tx_data[$];

    uart_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    uart_boot_ctrl #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_we", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("we_addr", 32'(bus.mem_addr), 32'(e.addr));
                check_eq("we_data", bus.mem_wdata, e.data);
                check_eq("we_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (bus.load_done === 1'b1) begin
            n_load++;
            check_eq("busy_at_load", 32'(bus.busy), 32'd0);
        end
        if (bus.cmd_err === 1'b1) n_cmd_err++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One assembled word; returns at the negedge after the DUT sampled it.
    task automatic send(input logic [31:0] w, input logic exp_ob, input string tag,
                        input logic push, input logic [ADDR_W-1:0] paddr);
        @(negedge clk);
        check_eq({tag, "_one_byte"}, 32'(bus.rx_one_byte), 32'(exp_ob));
        bus.rx_word = w;
        bus.rx_done = 1'b1;
        if (push) exp_q.push_back('{addr: paddr, data: w, cyc: cyc + 1});
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.rx_word = 32'h0;
    endtask

    task automatic wait_load(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.load_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_load_seen"}, 32'(seen), 32'd1);
        if (seen) check_eq({tag, "_one_byte_after"}, 32'(bus.rx_one_byte), 32'd1);
    endtask

    // WRITE command using tx_data; stops after n_send data words.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] len, input int n_send,
                            input string tag);
        logic [ADDR_W-1:0] a;
        send(32'h01, 1'b1, {tag, "_op"}, 1'b0, '0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
        idle(2);
        send(addr, 1'b0, {tag, "_addr"}, 1'b0, '0);
        idle(2);
        send(len, 1'b0, {tag, "_len"}, 1'b0, '0);
        if (len[LEN_W-1:0] == '0) begin
            wait_load(tag);
            return;
        end
        idle(2);
        a = addr[ADDR_W-1:0];
        for (int i = 0; i < n_send; i++) begin
            send(tx_data[i], 1'b0, {tag, "_data"}, 1'b1, a);
            a = a + 1'b1;
            if (i < n_send - 1) idle(2);
        end
        if (n_send == int'(len[LEN_W-1:0])) wait_load(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        bus.rx_word = 32'h0;
        bus.rx_done = 1'b0;
        idle(3);
        check_eq("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check_eq("rst_one_byte", 32'(bus.rx_one_byte), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_wdata", bus.mem_wdata, 32'd0);
        check_eq("rst_flags", {29'd0, bus.mem_we, bus.load_done, bus.cmd_err}, 32'd0);
        reset = 1'b0;
        idle(100);
        check_eq("idle_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);

        tx_data = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
        do_write(32'h0000_0010, 32'd3, 3, "w3");
        idle(3);

        send(32'h02, 1'b1, "run", 1'b0, '0);
        check_eq("run_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        idle(2);
        send(32'h03, 1'b1, "halt", 1'b0, '0);
        check_eq("halt_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        idle(2);
        send(32'h7F, 1'b1, "bad", 1'b0, '0);
        check_eq("bad_cmd_err", 32'(bus.cmd_err), 32'd1);
        idle(1);
        check_eq("bad_cmd_err_clr", 32'(bus.cmd_err), 32'd0);
        idle(1);
        send(32'h02, 1'b1, "run2", 1'b0, '0);
        check_eq("run2_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        idle(2);

        tx_data = '{32'hA5A5_0001, 32'h5A5A_0002};
        do_write(32'h0000_03FF, 32'd2, 2, "wrap");
        check_eq("write_keeps_hold", 32'(bus.cpu_hold), 32'd0);
        idle(3);
        do_write(32'h0000_0010, 32'd0, 0, "len0");
        check_eq("len0_busy", 32'(bus.busy), 32'd0);
        idle(3);

        tx_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        do_write(32'h0000_0020, 32'd4, 2, "abort");
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_we", 32'(bus.mem_we), 32'd0);
        check_eq("abort_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_one_byte", 32'(bus.rx_one_byte), 32'd1);
        idle(20);

        tx_data = '{32'h0BAD_F00D};
        do_write(32'h0000_0040, 32'd1, 1, "w1");
        idle(5);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check_eq("load_done_count", 32'(n_load), 32'd4);
        check_eq("cmd_err_count", 32'(n_cmd_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
